// File: rtl/tetris_input_conditioner.sv
// -----------------------------------------------------------------------------
// tetris_input_conditioner
//
// Conditions the raw Tetris push-buttons (left, right, rotate, drop) for the
// game/VGA controller. Each channel is independent: a two-flop synchronizer,
// a debouncer that accepts a level only after DEBOUNCE_CYCLES stable cycles,
// and a small FSM that emits a one-cycle move strobe on each accepted press
// and, when auto-repeat is enabled, on a delay/period schedule while held.
//
// Ports
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-low reset
//   btn_raw    in   [NUM_BTNS] asynchronous bouncy pins, 1 = pressed
//   repeat_en  in   [NUM_BTNS] per-channel auto-repeat enable, quasi-static
//   btn_level  out  [NUM_BTNS] debounced button state
//   btn_pulse  out  [NUM_BTNS] one-cycle strobe per accepted press or repeat
// -----------------------------------------------------------------------------
module tetris_input_conditioner #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 20000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic [NUM_BTNS-1:0] repeat_en,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LATCHED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_REPEAT  = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTNS-1:0] sync1_q, sync1_d;
  logic [NUM_BTNS-1:0] sync2_q, sync2_d;
  logic [NUM_BTNS-1:0] level_q, level_d;
  logic [NUM_BTNS-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0]    db_cnt_q  [NUM_BTNS];
  logic [CNT_W-1:0]    db_cnt_d  [NUM_BTNS];
  logic [CNT_W-1:0]    rpt_cnt_q [NUM_BTNS];
  logic [CNT_W-1:0]    rpt_cnt_d [NUM_BTNS];
  logic [1:0]          state_q   [NUM_BTNS];
  logic [1:0]          state_d   [NUM_BTNS];

  // Per-channel debounce decisions, shared by the FSM.
  logic [NUM_BTNS-1:0] differ;
  logic [NUM_BTNS-1:0] db_done;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] fall;

  // Synchronizer: only sync2 is used downstream.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce: count while the synchronized input disagrees with the accepted
  // level; any agreement (a glitch back) restarts the count from zero.
  always_comb begin
    differ  = '0;
    db_done = '0;
    rise    = '0;
    fall    = '0;
    level_d = level_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      differ[i]  = sync2_q[i] ^ level_q[i];
      db_done[i] = differ[i] && (db_cnt_q[i] == DB_LAST);
      rise[i]    = db_done[i] && sync2_q[i];
      fall[i]    = db_done[i] && !sync2_q[i];
      if (!differ[i] || db_done[i]) begin
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
      end
      if (db_done[i]) begin
        level_d[i] = sync2_q[i];
      end
    end
  end

  // Channel FSM. The initial pulse is registered on the same edge as the
  // level change. In HELD/REPEAT an accepted fall wins over a terminal count,
  // so release never produces a strobe.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            pulse_d[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
            state_d[i]   = repeat_en[i] ? ST_HELD : ST_LATCHED;
          end
        end
        ST_LATCHED: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            rpt_cnt_d[i] = '0;
            state_d[i]   = ST_IDLE;
          end else if (rpt_cnt_q[i] == RD_LAST) begin
            pulse_d[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
            state_d[i]   = ST_REPEAT;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          if (fall[i]) begin
            rpt_cnt_d[i] = '0;
            state_d[i]   = ST_IDLE;
          end else if (rpt_cnt_q[i] == RP_LAST) begin
            pulse_d[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_tetris_input_conditioner
//
// Directed bench for tetris_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Each scenario starts from reset; cycle 0
// is the instant reset is released and the scenario's raw inputs are applied.
// Per-cycle pulse/level samples are collected into bit masks (bit c = state
// after edge c) and compared with hand-computed masks.
// -----------------------------------------------------------------------------
module tb_tetris_input_conditioner;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  logic [127:0]  pm [NB];
  logic [127:0]  lm [NB];

  tetris_input_conditioner #(
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .CNT_W           (25)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] bit_at(input int i);
    return 128'(1) << i;
  endfunction

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Advance one clock edge, sample 1 time unit later, log into masks.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 128) begin
      for (int ch = 0; ch < NB; ch++) begin
        pm[ch][cyc] = btn_pulse[ch];
        lm[ch][cyc] = btn_level[ch];
      end
    end
  endtask

  task automatic begin_scn(input logic [NB-1:0] raw0, input logic [NB-1:0] ren);
    reset   = 1'b0;
    btn_raw = '0;
    step();
    step();
    reset     = 1'b1;
    btn_raw   = raw0;
    repeat_en = ren;
    cyc       = 0;
    for (int ch = 0; ch < NB; ch++) begin
      pm[ch] = '0;
      lm[ch] = '0;
    end
  endtask

  initial begin
    logic [127:0] exp_p;

    // Reset state
    reset   = 1'b0;
    btn_raw = 4'b1111;
    step();
    step();
    check("reset_level", 128'(btn_level), 128'(0));
    check("reset_pulse", 128'(btn_pulse), 128'(0));

    // Clean press on bit 1, no repeat; raw high cycles 0..29
    begin_scn(4'b0010, 4'b0000);
    while (cyc < 44) begin
      if (cyc == 30) btn_raw[1] = 1'b0;
      step();
    end
    check("clean_pulse1", pm[1], bit_at(6));
    check("clean_level1", lm[1], span(6, 35));
    check("clean_others", pm[0] | pm[2] | pm[3], '0);

    // Bounce on bit 0: 1,0,1,0 then stays 1 from cycle 4
    begin_scn(4'b0001, 4'b0000);
    while (cyc < 30) begin
      case (cyc)
        1: btn_raw[0] = 1'b0;
        2: btn_raw[0] = 1'b1;
        3: btn_raw[0] = 1'b0;
        4: btn_raw[0] = 1'b1;
        default: ;
      endcase
      step();
    end
    check("bounce_pulse0", pm[0], bit_at(10));
    check("bounce_level0", lm[0], span(10, 30));

    // Auto-repeat on bit 0, release at 40 (fall accepted at 46, coinciding
    // with a repeat terminal count), then press again at 60.
    begin_scn(4'b0001, 4'b0001);
    while (cyc < 80) begin
      if (cyc == 40) btn_raw[0] = 1'b0;
      if (cyc == 60) btn_raw[0] = 1'b1;
      step();
    end
    exp_p = bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25) |
            bit_at(28) | bit_at(31) | bit_at(34) | bit_at(37) | bit_at(40) |
            bit_at(43) | bit_at(66) | bit_at(76) | bit_at(79);
    check("repeat_pulse0", pm[0], exp_p);
    check("repeat_level0", lm[0], span(6, 45) | span(66, 80));
    check("release_at_terminal", 128'(pm[0][46]), 128'(0));

    // Simultaneous presses, repeat only on bits 0 and 1
    begin_scn(4'b1111, 4'b0011);
    while (cyc < 25) step();
    exp_p = bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25);
    check("simul_pulse0", pm[0], exp_p);
    check("simul_pulse1", pm[1], exp_p);
    check("simul_pulse2", pm[2], bit_at(6));
    check("simul_pulse3", pm[3], bit_at(6));
    check("simul_level", lm[0] & lm[1] & lm[2] & lm[3], span(6, 25));

    // Reset mid-hold: reset low for edges 20 and 21, button stays pressed
    begin_scn(4'b0001, 4'b0001);
    while (cyc < 34) begin
      if (cyc == 19) reset = 1'b0;
      if (cyc == 21) reset = 1'b1;
      step();
      if (cyc == 20 || cyc == 21) begin
        check($sformatf("midrst_level_c%0d", cyc), 128'(btn_level), 128'(0));
        check($sformatf("midrst_pulse_c%0d", cyc), 128'(btn_pulse), 128'(0));
      end
    end
    check("midrst_pulse0", pm[0], bit_at(6) | bit_at(16) | bit_at(19) | bit_at(27));
    check("midrst_level0", lm[0], span(6, 19) | span(27, 34));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tetris_input_conditioner.md
# tetris_input_conditioner

Synchronizes, debounces and auto-repeats the raw Tetris push-buttons (left, right, rotate, drop). It produces clean level and single-cycle move pulses that feed the move inputs of `VGAController` directly. It sits between the board button pins and the game/VGA controller, in the 100 MHz `clk` domain. All channels are independent and identical.

## Interface
- `NUM_BTNS`, 4, number of button channels (bit 0 left, 1 right, 2 rotate, 3 drop)
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a level change (10 ms)
- `REPEAT_DELAY`, 20000000, cycles from the initial press pulse to the first repeat pulse (200 ms)
- `REPEAT_PERIOD`, 5000000, cycles between subsequent repeat pulses (50 ms)
- `CNT_W`, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
- `clk`  in  1  100 MHz system clock
- `reset`  in  1  synchronous, active-low reset
- `btn_raw`  in  NUM_BTNS  asynchronous, bouncy button pins, 1 = pressed
- `repeat_en`  in  NUM_BTNS  per-channel auto-repeat enable (typically left/right = 1, rotate/drop = 0); quasi-static
- `btn_level`  out  NUM_BTNS  debounced button state
- `btn_pulse`  out  NUM_BTNS  one-cycle move strobe per accepted press or repeat

## Operation
- Reset, when `reset` = 0 at a rising edge:
  - synchronizer flops, `btn_level`, `btn_pulse`, all counters = 0;
  - every channel FSM = IDLE.
- Synchronizer: two-flop chain per bit. All downstream logic uses only the second flop, `sync`.
- Debounce, per channel:
  - `db_cnt` increments while `sync` != `btn_level` and clears when they are equal.
  - When `db_cnt` = DEBOUNCE_CYCLES-1 and `sync` still differs, `btn_level` <= `sync` and `db_cnt` <= 0.
  - Any glitch back to the old level restarts the count.
- Channel FSM; `rpt_cnt` is the repeat counter:
  - IDLE: on accepted rise of `btn_level`, assert `btn_pulse` for 1 cycle and clear `rpt_cnt`. Go to HELD if `repeat_en`, otherwise to LATCHED.
  - LATCHED: no further pulses. Return to IDLE on accepted fall of `btn_level`.
  - HELD: `rpt_cnt` counts up. At REPEAT_DELAY-1, pulse, clear `rpt_cnt`, go to REPEAT.
  - REPEAT: `rpt_cnt` counts up. At REPEAT_PERIOD-1, pulse and clear `rpt_cnt`. Stay in REPEAT.
  - HELD or REPEAT: an accepted fall goes to IDLE immediately, with no pulse that cycle, even if the count terminates the same cycle.
- `repeat_en` is sampled only on the IDLE exit. Changing it while held has no effect until the next press.
- Simultaneous presses on several channels each pulse independently, including in the same cycle. Arbitration (e.g. left+right) belongs to the consumer.
- Release never produces a pulse.

## Timing
- Raw edge held stable from cycle 0 → `btn_level` and the initial `btn_pulse` both registered at cycle DEBOUNCE_CYCLES+2.
  - 2 cycles come from the synchronizer; the pulse is coincident with the level change.
- First repeat pulse: REPEAT_DELAY cycles after the initial pulse.
- Later repeats: every REPEAT_PERIOD cycles.
- `btn_pulse` is exactly one cycle high. Minimum spacing between pulses on a channel is min(REPEAT_PERIOD, 2·DEBOUNCE_CYCLES).
- Reset asserted mid-hold: outputs are 0 the cycle after the reset edge.
  - After reset release with the button still held, a fresh press is accepted after DEBOUNCE_CYCLES+2 cycles and pulses once.
- Counters never wrap. Each is cleared at its terminal value.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTNS=4.
- Clean press, bit 1 (`repeat_en`=0), raw high at cycle 0 for 30 cycles → `btn_level[1]` rises at cycle 6 with a single `btn_pulse[1]` at cycle 6. `btn_level[1]` falls at cycle 36, with no pulse on release.
- Bounce, bit 0: raw toggles 1,0,1,0 on alternating cycles, then stays 1 → no pulse during bouncing. Exactly one pulse 6 cycles after the last edge.
- Auto-repeat, bit 0 (`repeat_en[0]`=1), held from cycle 0 to cycle 40 → pulses at cycles 6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43.
  - The raw fall at 40 is accepted at 46, so the FSM stays in REPEAT through 43.
  - No pulses after cycle 46.
- Release coinciding with the repeat terminal count: set up so the accepted fall lands on the same cycle as a repeat terminal → no pulse that cycle, FSM returns to IDLE.
- Simultaneous channels: `btn_raw`=4'b1111 at cycle 0, `repeat_en`=4'b0011 → all four pulse at cycle 6. Only bits 0 and 1 pulse again at cycle 16.
- Reset mid-hold: bit 0 held, `reset`=0 for 2 cycles at cycle 20 → outputs 0 from cycle 21. After release, `btn_pulse[0]` fires once, 6 cycles after `reset` returns high.
